// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a synchronized lock,
// qualifies it for a stable window, then releases the PLL-domain reset.
module pll_lock_ctrl #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] lol_cnt
);

    localparam int unsigned CNT_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned CNT_MAX = (CNT_AB > STABLE_CYCLES) ? CNT_AB : STABLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       retry_n;
    logic [7:0]       lol_n;
    logic [1:0]       sync_q;
    logic             locked_s;

    assign locked_s = sync_q[1];

    // Two-flop synchronizer for the asynchronous lock indication
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) sync_q <= 2'b00;
        else     sync_q <= {sync_q[0], pll_locked};
    end

    // State, counters and registered Moore decodes of the next state
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            retry_cnt <= 4'd0;
            lol_cnt   <= 8'd0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            retry_cnt <= retry_n;
            lol_cnt   <= lol_n;
            pll_rst   <= (state_n == RESET_PLL) || (state_n == FAIL);
            sys_rst   <= (state_n != RUN);
            ready     <= (state_n == RUN);
            fail      <= (state_n == FAIL);
        end
    end

    // Next-state logic; counter terminal compares keep the shared counter from wrapping
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        retry_n = retry_cnt;
        lol_n   = lol_cnt;
        case (state)
            RESET_PLL: begin
                if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_n = STABLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    cnt_n = '0;
                    if (retry_cnt == 4'(MAX_RETRIES)) begin
                        state_n = FAIL;
                    end else begin
                        state_n = RESET_PLL;
                        retry_n = retry_cnt + 4'd1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_n = RUN;
                    cnt_n   = '0;
                    retry_n = 4'd0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_n = RESET_PLL;
                    cnt_n   = '0;
                    lol_n   = (lol_cnt == 8'd255) ? lol_cnt : lol_cnt + 8'd1;
                end
            end
            FAIL: begin
                cnt_n = '0;
            end
            default: begin
                state_n = RESET_PLL;
                cnt_n   = '0;
            end
        endcase
        // A restart request overrides every other transition
        if (restart) begin
            state_n = RESET_PLL;
            cnt_n   = '0;
            retry_n = 4'd0;
        end
    end

endmodule
